// File: rtl/batch_stream_host.sv
// Host-side stream engine: for each sample, stream ss+1 words from input memory to
// the source port, then write ds+1 result beats from the destination port to output memory.
module batch_stream_host #(
    parameter int DW = 32,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [11:0]   ss,
    input  logic [11:0]   ds,
    input  logic [9:0]    n_samp,
    output logic          busy,
    output logic          done,
    output logic          in_re,
    output logic [AW-1:0] in_ra,
    input  logic [DW-1:0] in_rd,
    output logic          src_valid,
    output logic          src_last,
    output logic [DW-1:0] src_data,
    input  logic          src_ready,
    input  logic          dst_valid,
    input  logic [DW-1:0] dst_data,
    output logic          dst_ready,
    output logic          out_we,
    output logic [AW-1:0] out_wa,
    output logic [DW-1:0] out_wd
);

    typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

    state_t        state, state_nx;
    logic [11:0]   ss_q, ds_q;
    logic [9:0]    n_q, samp;
    logic [11:0]   rd_cnt, src_cnt, dst_cnt;
    logic          rd_done;
    logic [AW-1:0] in_ptr, out_ptr;
    logic [DW-1:0] fifo [2];
    logic          wr_sel, rd_sel, inflight;
    logic [1:0]    count;
    logic          pop, push, dst_hs, last_dst, batch_end, begin_batch;
    logic [2:0]    room_use;

    // Handshake rule on both ports: a beat transfers in a cycle where valid and ready
    // are both high; once raised, source valid/data/last hold until that cycle.
    assign src_valid   = (count != 2'd0);
    assign src_data    = fifo[rd_sel];
    assign src_last    = src_valid && (src_cnt == ss_q);
    assign pop         = src_valid && src_ready;
    assign push        = inflight;
    assign dst_ready   = (state == RECV);
    assign dst_hs      = dst_valid && dst_ready;
    assign last_dst    = dst_hs && (dst_cnt == ds_q);
    assign batch_end   = last_dst && (samp == n_q);
    assign begin_batch = (state == IDLE) && start;
    assign busy        = (state != IDLE);
    assign in_ra       = in_ptr;

    // Occupancy after this cycle's pop plus the read already in flight must leave a free slot.
    assign room_use = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
    assign in_re    = (state == SEND) && !rd_done && (room_use < 3'd2);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEND;
            SEND:    if (pop && src_last) state_nx = RECV;
            RECV:    if (last_dst) state_nx = (samp == n_q) ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q     <= '0;
            ds_q     <= '0;
            n_q      <= '0;
            samp     <= '0;
            rd_cnt   <= '0;
            rd_done  <= 1'b0;
            src_cnt  <= '0;
            dst_cnt  <= '0;
            in_ptr   <= '0;
            out_ptr  <= '0;
            done     <= 1'b0;
            out_we   <= 1'b0;
            out_wa   <= '0;
            out_wd   <= '0;
        end else begin
            done   <= batch_end;
            out_we <= dst_hs;
            if (begin_batch) begin
                ss_q    <= ss;
                ds_q    <= ds;
                n_q     <= n_samp;
                samp    <= '0;
                rd_cnt  <= '0;
                rd_done <= 1'b0;
                src_cnt <= '0;
                dst_cnt <= '0;
                in_ptr  <= '0;
                out_ptr <= '0;
            end
            if (in_re) begin
                in_ptr <= in_ptr + AW'(1);
                rd_cnt <= rd_cnt + 12'd1;
                if (rd_cnt == ss_q) rd_done <= 1'b1;
            end
            if (pop) src_cnt <= src_last ? 12'd0 : src_cnt + 12'd1;
            if (dst_hs) begin
                dst_cnt <= last_dst ? 12'd0 : dst_cnt + 12'd1;
                out_wa  <= out_ptr;
                out_wd  <= dst_data;
                out_ptr <= out_ptr + AW'(1);
            end
            // Moving on to the next sample re-arms the read side; in_ptr keeps running.
            if (last_dst && !batch_end) begin
                samp    <= samp + 10'd1;
                rd_cnt  <= '0;
                rd_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= in_re;
            if (push) begin
                fifo[wr_sel] <= in_rd;
                wr_sel       <= ~wr_sel;
            end
            if (pop) rd_sel <= ~rd_sel;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_batch_stream_host.sv
// Self-checking bench for batch_stream_host: input memory model, source/destination
// drivers, and scoreboard queues for source beats and output-memory writes.
module tb_batch_stream_host;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   ss = '0;
  logic [11:0]   ds = '0;
  logic [9:0]    n_samp = '0;
  logic          busy, done, in_re, src_valid, src_last, dst_ready, out_we;
  logic [AW-1:0] in_ra, out_wa;
  logic [DW-1:0] in_rd = '0;
  logic [DW-1:0] src_data, out_wd;
  logic          src_ready = 1'b0;
  logic          dst_valid = 1'b0;
  logic [DW-1:0] dst_data = '0;

  batch_stream_host #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ss(ss), .ds(ds), .n_samp(n_samp),
    .busy(busy), .done(done), .in_re(in_re), .in_ra(in_ra), .in_rd(in_rd),
    .src_valid(src_valid), .src_last(src_last), .src_data(src_data), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .out_we(out_we), .out_wa(out_wa), .out_wd(out_wd)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // input memory: mem[a] = 0x100 + a, one-cycle read latency
  always @(posedge clk) if (in_re) in_rd <= 32'h100 + DW'(in_ra);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard state
  logic [DW:0]      src_q[$];
  logic [AW+DW-1:0] wr_q[$];
  logic [DW:0]      src_e;
  logic [AW+DW-1:0] wr_e;
  logic [AW-1:0]    rd_exp = '0;
  logic [AW-1:0]    out_exp = '0;
  int  ahead = 0;
  int  done_cnt = 0;
  int  dcnt = 0;
  int  cur_ds = 0;
  int  g_rmode = 0;
  int  wrap_hits = 0;
  bit  send_phase = 1'b0;
  bit  prev_stall = 1'b0;
  bit  burst = 1'b0;
  bit  wrap_watch = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      burst      = 1'b0;
      wrap_watch = 1'b0;
    end else begin
      if (send_phase && dst_valid) check("dst_ready_in_send", dst_ready, 0);
      if (prev_stall) begin
        check("src_hold_valid", src_valid, 1);
        check("src_hold_data", src_data, prev_data);
      end
      if (g_rmode == 0 && burst) check("src_no_bubble", src_valid, 1);
      if (wrap_watch) begin
        check("wrap_next_re", in_re, 1);
        check("wrap_next_ra", in_ra, 0);
        wrap_watch = 1'b0;
      end
      if (in_re) begin
        check("in_ra", in_ra, rd_exp);
        if (in_ra == '1) begin
          wrap_watch = 1'b1;
          wrap_hits++;
        end
        rd_exp = rd_exp + AW'(1);
        ahead++;
      end
      burst = 1'b0;
      if (src_valid && src_ready) begin
        ahead--;
        if (src_q.size() == 0) begin
          check("src_extra_beat", 1, 0);
        end else begin
          src_e = src_q.pop_front();
          check("src_data", src_data, src_e[DW-1:0]);
          check("src_last", src_last, src_e[DW]);
        end
        if (src_last) send_phase = 1'b0;
        else burst = 1'b1;
      end
      if (in_re) check("reads_ahead_le2", ahead <= 2, 1);
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      if (dst_valid && dst_ready) begin
        if (dcnt == cur_ds) begin
          dcnt = 0;
          send_phase = 1'b1;
        end else begin
          dcnt++;
        end
      end
      if (out_we) begin
        if (wr_q.size() == 0) begin
          check("out_extra_write", 1, 0);
        end else begin
          wr_e = wr_q.pop_front();
          check("out_wa", out_wa, wr_e[AW+DW-1:DW]);
          check("out_wd", out_wd, wr_e[DW-1:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_with_we", out_we, 1);
        check("done_busy_low", busy, 0);
      end
    end
  end

  // driver tasks
  task automatic clear_model();
    src_q.delete();
    wr_q.delete();
    rd_exp     = '0;
    out_exp    = '0;
    ahead      = 0;
    dcnt       = 0;
    done_cnt   = 0;
    send_phase = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_re"}, in_re, 0);
    check({tag, "_in_ra"}, in_ra, 0);
    check({tag, "_src_valid"}, src_valid, 0);
    check({tag, "_src_last"}, src_last, 0);
    check({tag, "_src_data"}, src_data, 0);
    check({tag, "_dst_ready"}, dst_ready, 0);
    check({tag, "_out_we"}, out_we, 0);
    check({tag, "_out_wa"}, out_wa, 0);
    check({tag, "_out_wd"}, out_wd, 0);
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random. poke pulses start during SEND.
  task automatic run_batch(input int s, input int d, input int n, input int rmode,
                           input bit gaps, input bit poke, input logic [DW-1:0] dbase);
    logic [AW-1:0] a;
    int  tmo;
    int  beat;
    bit  fin;
    bit  abort;
    clear_model();
    cur_ds  = d;
    g_rmode = rmode;
    a = '0;
    for (int k = 0; k <= n; k++) begin
      for (int i = 0; i <= s; i++) begin
        src_q.push_back({(i == s), 32'h100 + DW'(a)});
        a = a + AW'(1);
      end
    end
    @(posedge clk); #1;
    start = 1'b1; ss = 12'(s); ds = 12'(d); n_samp = 10'(n);
    src_ready = (rmode != 2);
    send_phase = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ss = 12'($urandom); ds = 12'($urandom); n_samp = 10'($urandom);
    check("busy_t1", busy, 1);
    check("in_re_t1", in_re, 1);
    check("src_valid_t1", src_valid, 0);
    @(posedge clk); #1;
    check("src_valid_t2", src_valid, 0);
    @(posedge clk); #1;
    check("src_valid_t3", src_valid, 1);
    fin = 1'b0;
    abort = 1'b0;
    fork
      begin
        int p;
        p = 1;
        while (!fin) begin
          @(posedge clk); #1;
          case (rmode)
            0:       src_ready = 1'b1;
            1:       src_ready = ((p % 4) == 0) || ((p % 4) == 3);
            default: src_ready = 1'($urandom_range(0, 1));
          endcase
          if (poke) start = (p == 3);
          p++;
        end
      end
      begin
        beat = 0;
        for (int k = 0; k <= n && !abort; k++) begin
          for (int b = 0; b <= d && !abort; b++) begin
            if (gaps) begin
              dst_valid = 1'b0;
              repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            dst_valid = 1'b1;
            dst_data  = dbase + DW'(beat);
            tmo = 0;
            forever begin
              @(negedge clk);
              if (dst_ready) break;
              tmo++;
              if (tmo > 12000) break;
            end
            if (!dst_ready) begin
              check("dst_handshake_timeout", 0, 1);
              abort = 1'b1;
            end else begin
              wr_q.push_back({out_exp, dst_data});
              out_exp = out_exp + AW'(1);
              beat++;
              @(posedge clk); #1;
            end
          end
        end
        dst_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("src_q_drained", src_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        fin = 1'b1;
      end
    join
    start = 1'b0;
    src_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_batch(3, 1, 0, 0, 1'b0, 1'b0, 32'hA);        // single sample
    run_batch(7, 2, 0, 1, 1'b1, 1'b0, 32'h200);      // source backpressure 1,0,0,1
    run_batch(0, 0, 2, 0, 1'b0, 1'b0, 32'h300);      // multi-sample, single beat
    run_batch(5, 3, 1, 2, 1'b0, 1'b0, 32'h400);      // stray result beats held during SEND
    run_batch(7, 1, 1, 0, 1'b0, 1'b1, 32'h500);      // start while busy is ignored

    // reset mid-SEND with source stalled
    clear_model();
    g_rmode = 1;
    src_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; ss = 12'd7; ds = 12'd1; n_samp = 10'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_send_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_batch(2, 1, 1, 2, 1'b1, 1'b0, 32'h600);      // restarts at in_ra = 0

    wrap_hits = 0;
    run_batch(4094, 0, 16, 0, 1'b0, 1'b0, 32'h700);  // input pointer wraps mid-sample
    check("wrap_seen_once", wrap_hits, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
